// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and address type for the rf_sb register file
package rf_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int ZERO_REG_DEF = 1;
  typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with mark/clear and two read ports (bypass under RF_BYPASS_EN)
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] Rw,
  input  logic          Mark,
  input  logic [AW-1:0] Rm,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic          BusyA,
  output logic          BusyB
);
  logic [2**AW-1:0] r_busy;
  logic w_wr_ok, w_mk_ok, w_a_z, w_b_z;
  assign w_wr_ok = WrEn && !((ZERO_REG != 0) && (Rw == '0));
  assign w_mk_ok = Mark && !((ZERO_REG != 0) && (Rm == '0));
  assign w_a_z = (ZERO_REG != 0) && (Ra == '0);
  assign w_b_z = (ZERO_REG != 0) && (Rb == '0);
  // writeback clears, mark sets; mark is assigned last so the younger op wins on the same address
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) r_busy <= '0;
    else begin
      if (w_wr_ok) r_busy[Rw] <= 1'b0;
      if (w_mk_ok) r_busy[Rm] <= 1'b1;
    end
`ifdef RF_BYPASS_EN
  logic w_byp_a, w_byp_b, w_mk_w;
  assign w_mk_w = w_mk_ok && (Rm == Rw);
  assign w_byp_a = !Reset && w_wr_ok && (Ra == Rw);
  assign w_byp_b = !Reset && w_wr_ok && (Rb == Rw);
  // a same-cycle writeback forwards its post-edge busy state (still busy if re-marked)
  always_comb begin
    BusyA = w_byp_a ? w_mk_w : w_a_z ? 1'b0 : r_busy[Ra];
    BusyB = w_byp_b ? w_mk_w : w_b_z ? 1'b0 : r_busy[Rb];
  end
`else
  // plain busy lookup; hard-wired register 0 is never busy
  always_comb begin
    BusyA = w_a_z ? 1'b0 : r_busy[Ra];
    BusyB = w_b_z ? 1'b0 : r_busy[Rb];
  end
`endif
endmodule

// File: rtl/rf_sb.sv
// rf_sb: parametrised 2R/1W register file with scoreboard stall; RF_BYPASS_EN enables write-to-read bypass
module rf_sb
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] Rw,
  input  logic [DW-1:0] busW,
  input  logic          Mark,
  input  logic [AW-1:0] Rm,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  input  logic          ReA,
  input  logic          ReB,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  output logic          BusyA,
  output logic          BusyB,
  output logic          Stall
);
  logic [DW-1:0] r_rf [2**AW];
  logic w_wr_ok, w_a_z, w_b_z;
  assign w_wr_ok = WrEn && !((ZERO_REG != 0) && (Rw == '0));
  assign w_a_z = (ZERO_REG != 0) && (Ra == '0);
  assign w_b_z = (ZERO_REG != 0) && (Rb == '0);
  // data array: async clear, synchronous write
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) for (int i = 0; i < 2**AW; i++) r_rf[i] <= '0;
    else if (w_wr_ok) r_rf[Rw] <= busW;
`ifdef RF_BYPASS_EN
  logic w_byp_a, w_byp_b;
  assign w_byp_a = !Reset && w_wr_ok && (Ra == Rw);
  assign w_byp_b = !Reset && w_wr_ok && (Rb == Rw);
  // read ports forward write data for the register being written this cycle
  always_comb begin
    busA = w_byp_a ? busW : w_a_z ? '0 : r_rf[Ra];
    busB = w_byp_b ? busW : w_b_z ? '0 : r_rf[Rb];
  end
`else
  // read ports return array contents only
  always_comb begin
    busA = w_a_z ? '0 : r_rf[Ra];
    busB = w_b_z ? '0 : r_rf[Rb];
  end
`endif
  rf_scoreboard #(.AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .Rw(Rw), .Mark(Mark), .Rm(Rm),
    .Ra(Ra), .Rb(Rb), .BusyA(BusyA), .BusyB(BusyB)
  );
  assign Stall = (ReA & BusyA) | (ReB & BusyB);
endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed table-driven bench for rf_sb (default and DW=16/AW=3/ZERO_REG=0 instances)
module tb_rf_sb;
  logic clk = 0, Reset = 1;
  always #5 clk = ~clk;
  logic WrEn, Mark, ReA, ReB;
  logic [4:0] Rw, Rm, Ra, Rb;
  logic [31:0] busW, busA, busB;
  logic BusyA, BusyB, Stall;
  logic s_WrEn, s_Mark, s_ReA, s_ReB;
  logic [2:0] s_Rw, s_Rm, s_Ra, s_Rb;
  logic [15:0] s_busW, s_busA, s_busB;
  logic s_BusyA, s_BusyB, s_Stall;
  int errors = 0, checks = 0;

  rf_sb dut (.Clk(clk), .Reset(Reset), .WrEn(WrEn), .Rw(Rw), .busW(busW), .Mark(Mark), .Rm(Rm),
    .Ra(Ra), .Rb(Rb), .ReA(ReA), .ReB(ReB), .busA(busA), .busB(busB), .BusyA(BusyA), .BusyB(BusyB), .Stall(Stall));
  rf_sb #(.DW(16), .AW(3), .ZERO_REG(0)) dut_s (.Clk(clk), .Reset(Reset), .WrEn(s_WrEn), .Rw(s_Rw), .busW(s_busW),
    .Mark(s_Mark), .Rm(s_Rm), .Ra(s_Ra), .Rb(s_Rb), .ReA(s_ReA), .ReB(s_ReB), .busA(s_busA), .busB(s_busB),
    .BusyA(s_BusyA), .BusyB(s_BusyB), .Stall(s_Stall));

  typedef struct {
    logic wr; logic [4:0] rw; logic [31:0] wd; logic mk; logic [4:0] rm;
    logic [4:0] ra; logic [4:0] rb; logic rea; logic reb;
    logic [31:0] ea; logic eba; logic [31:0] eb; logic ebb; logic est;
  } vec_t;
  vec_t v[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    WrEn = t.wr; Rw = t.rw; busW = t.wd; Mark = t.mk; Rm = t.rm;
    Ra = t.ra; Rb = t.rb; ReA = t.rea; ReB = t.reb;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input logic eba,
                         input logic [31:0] eb, input logic ebb, input logic est);
    chk({tag, "_busA"}, busA, ea);
    chk({tag, "_BusyA"}, {31'd0, BusyA}, {31'd0, eba});
    chk({tag, "_busB"}, busB, eb);
    chk({tag, "_BusyB"}, {31'd0, BusyB}, {31'd0, ebb});
    chk({tag, "_Stall"}, {31'd0, Stall}, {31'd0, est});
  endtask

  initial begin
    //        wr rw  wd            mk rm  ra  rb  rea reb  ea          eba eb          ebb est
    v[0]  = '{1, 11, 32'h0000_1111, 0, 0,  0,  0,  0,  0,  32'h0,      0,  32'h0,      0,  0};
    v[1]  = '{1, 0,  32'hFFFF_FFFF, 0, 0,  11, 0,  0,  0,  32'h1111,   0,  32'h0,      0,  0};
    v[2]  = '{0, 0,  32'h0,         1, 18, 0,  11, 0,  0,  32'h0,      0,  32'h1111,   0,  0};
    v[3]  = '{0, 0,  32'h0,         1, 0,  18, 11, 1,  1,  32'h0,      1,  32'h1111,   0,  1};
    v[4]  = '{0, 0,  32'h0,         0, 0,  18, 0,  0,  1,  32'h0,      1,  32'h0,      0,  0};
    v[5]  = '{1, 18, 32'hA,         0, 0,  11, 0,  1,  1,  32'h1111,   0,  32'h0,      0,  0};
    v[6]  = '{0, 0,  32'h0,         0, 0,  18, 0,  1,  0,  32'hA,      0,  32'h0,      0,  0};
    v[7]  = '{1, 19, 32'h2,         1, 19, 18, 0,  0,  0,  32'hA,      0,  32'h0,      0,  0};
    v[8]  = '{0, 0,  32'h0,         0, 0,  0,  19, 1,  1,  32'h0,      0,  32'h2,      1,  1};
    v[9]  = '{1, 20, 32'h5,         0, 0,  19, 18, 0,  1,  32'h2,      1,  32'hA,      0,  0};
`ifdef RF_BYPASS_EN
    v[10] = '{1, 20, 32'hA,         0, 0,  20, 19, 1,  0,  32'hA,      0,  32'h2,      1,  0};
    v[11] = '{1, 21, 32'h7,         1, 21, 21, 21, 1,  0,  32'h7,      1,  32'h7,      1,  1};
    v[13] = '{1, 21, 32'h9,         0, 0,  21, 0,  1,  0,  32'h9,      0,  32'h0,      0,  0};
`else
    v[10] = '{1, 20, 32'hA,         0, 0,  20, 19, 1,  0,  32'h5,      0,  32'h2,      1,  0};
    v[11] = '{1, 21, 32'h7,         1, 21, 21, 21, 1,  0,  32'h0,      0,  32'h0,      0,  0};
    v[13] = '{1, 21, 32'h9,         0, 0,  21, 0,  1,  0,  32'h7,      1,  32'h0,      0,  1};
`endif
    v[12] = '{0, 0,  32'h0,         0, 0,  20, 21, 0,  1,  32'hA,      0,  32'h7,      1,  1};
    v[14] = '{0, 0,  32'h0,         0, 0,  21, 0,  1,  0,  32'h9,      0,  32'h0,      0,  0};
    s_WrEn = 0; s_Mark = 0; s_ReA = 0; s_ReB = 0;
    s_Rw = 0; s_Rm = 0; s_Ra = 0; s_Rb = 0; s_busW = 0;
    WrEn = 1; Rw = 8; busW = 32'h1111; Mark = 1; Rm = 8; Ra = 8; Rb = 8; ReA = 1; ReB = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("in_reset", 32'h0, 0, 32'h0, 0, 0);
    Reset = 0; WrEn = 0; Mark = 0;
    @(negedge clk);
    chk_all("post_reset", 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk_all($sformatf("v%0d", i), v[i].ea, v[i].eba, v[i].eb, v[i].ebb, v[i].est);
    end
    @(negedge clk);
    WrEn = 0; Mark = 1; Rm = 22; Ra = 21; Rb = 22; ReA = 1; ReB = 1;
    @(negedge clk);
    Mark = 0;
    #1;
    chk_all("pre_async", 32'h9, 0, 32'h0, 1, 1);
    #1 Reset = 1;
    #1;
    chk_all("async_rst", 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk);
    Reset = 0; Ra = 11; Rb = 18;
    #1;
    chk_all("after_async", 32'h0, 0, 32'h0, 0, 0);
    @(negedge clk);
    s_WrEn = 1; s_Rw = 0; s_busW = 16'hBEEF;
    @(negedge clk);
    s_Rw = 7; s_busW = 16'h1234; s_Mark = 1; s_Rm = 0;
    @(negedge clk);
    s_WrEn = 0; s_Mark = 0; s_Ra = 0; s_Rb = 7; s_ReA = 1; s_ReB = 0;
    #1;
    chk("s_busA_r0", {16'd0, s_busA}, 32'hBEEF);
    chk("s_busB_r7", {16'd0, s_busB}, 32'h1234);
    chk("s_BusyA_r0", {31'd0, s_BusyA}, 32'd1);
    chk("s_Stall", {31'd0, s_Stall}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
